// File: rtl/ysyx_23060236_rd_xbar.sv
// ysyx_23060236_rd_xbar
//
// Single-master, two-slave AXI-lite read crossbar. One read is in flight at a
// time: the master address is captured in IDLE, decoded to CLINT, SoC or an
// unmapped hole, forwarded to the chosen slave (ADDR), and the slave's read
// data is passed back combinationally (DATA). Unmapped reads never reach a
// slave; the crossbar answers them itself with DECERR (ERR).
//
// Ports
//   clock, reset                       single clock, async active-high reset
//   araddr/arvalid/arready             master read-address channel
//   rdata/rresp/rvalid/rready          master read-data channel
//   clint_araddr/arvalid/arready       CLINT read-address channel
//   clint_rdata/rresp/rvalid/rready    CLINT read-data channel
//   soc_araddr/arvalid/arready         SoC read-address channel
//   soc_rdata/rresp/rvalid/rready      SoC read-data channel
module ysyx_23060236_rd_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int          CLINT_AW   = 16,
  parameter logic [31:0] UNMAP_TOP  = 32'h1000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // master
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // CLINT
  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  // SoC
  output logic [31:0] soc_araddr,
  output logic        soc_arvalid,
  input  logic        soc_arready,
  input  logic [31:0] soc_rdata,
  input  logic [1:0]  soc_rresp,
  input  logic        soc_rvalid,
  output logic        soc_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] addr_p0;
  logic        tgt_clint_p0;   // 1: CLINT, 0: SoC
  logic        load;
  logic        dec_clint;
  logic        dec_unmapped;

  // Address decode on the incoming master address
  always_comb begin
    dec_clint    = (araddr[31:CLINT_AW] == CLINT_BASE[31:CLINT_AW]);
    dec_unmapped = !dec_clint && (araddr < UNMAP_TOP);
  end

  assign load = (state == IDLE) && arvalid;

  // Stage p0: state, captured address and target
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_p0      <= 32'h0;
      tgt_clint_p0 <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        addr_p0      <= araddr;
        tgt_clint_p0 <= dec_clint;
      end
    end
  end

  // Both slaves see the captured address; only arvalid qualifies it.
  assign clint_araddr = addr_p0;
  assign soc_araddr   = addr_p0;

  // Next state and all handshake/payload outputs. Everything is a function of
  // the state register, so an asynchronous reset drops every strobe at once.
  always_comb begin
    state_next    = state;
    arready       = 1'b0;
    rvalid        = 1'b0;
    rdata         = 32'h0;
    rresp         = 2'b00;
    clint_arvalid = 1'b0;
    soc_arvalid   = 1'b0;
    clint_rready  = 1'b0;
    soc_rready    = 1'b0;

    case (state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          state_next = dec_unmapped ? ERR : ADDR;
        end
      end

      ADDR: begin
        if (tgt_clint_p0) begin
          clint_arvalid = 1'b1;
          if (clint_arready) state_next = DATA;
        end else begin
          soc_arvalid = 1'b1;
          if (soc_arready) state_next = DATA;
        end
      end

      DATA: begin
        if (tgt_clint_p0) begin
          rvalid       = clint_rvalid;
          rdata        = clint_rdata;
          rresp        = clint_rresp;
          clint_rready = rready;
          if (clint_rvalid && rready) state_next = IDLE;
        end else begin
          rvalid     = soc_rvalid;
          rdata      = soc_rdata;
          rresp      = soc_rresp;
          soc_rready = rready;
          if (soc_rvalid && rready) state_next = IDLE;
        end
      end

      ERR: begin
        // Locally generated DECERR for the unmapped hole
        rvalid = 1'b1;
        rresp  = 2'b11;
        if (rready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/ysyx_23060236_rd_xbar.md
YSYX_23060236_RD_XBAR -- requirements
Module: ysyx_23060236_rd_xbar

Interface
REQ-001 SHALL have parameter CLINT_BASE, 32'h0200_0000, base address of the CLINT window.
REQ-002 SHALL have parameter CLINT_AW, 16, log2 of the CLINT window size in bytes.
REQ-003 SHALL have parameter UNMAP_TOP, 32'h1000_0000; addresses below this value and outside the CLINT window are unmapped.
REQ-004 SHALL have port clock, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports araddr (in, 32), arvalid (in, 1) and arready (out, 1) as the master read-address channel.
REQ-007 SHALL have ports rdata (out, 32), rresp (out, 2), rvalid (out, 1) and rready (in, 1) as the master read-data channel.
REQ-008 SHALL have ports clint_araddr (out, 32), clint_arvalid (out, 1) and clint_arready (in, 1) as the CLINT read-address channel.
REQ-009 SHALL have ports clint_rdata (in, 32), clint_rresp (in, 2), clint_rvalid (in, 1) and clint_rready (out, 1) as the CLINT read-data channel.
REQ-010 SHALL have ports soc_araddr, soc_arvalid, soc_arready, soc_rdata, soc_rresp, soc_rvalid and soc_rready, identical in width and direction to the clint_* ports, as the SoC channel.

Function
REQ-011 SHALL implement an FSM with four states: IDLE, ADDR, DATA and ERR; one outstanding transaction maximum.
REQ-012 SHALL drive arready=1 only in IDLE (a combinational function of state).
REQ-013 IDLE with arvalid=1 SHALL register araddr and the decoded target, then go to ADDR (CLINT/SoC target) or ERR (unmapped target).
REQ-014 Decode SHALL be: CLINT if araddr[31:CLINT_AW]==CLINT_BASE[31:CLINT_AW]; else unmapped if araddr<UNMAP_TOP; else SoC.
REQ-015 SHALL drive clint_araddr and soc_araddr from the registered address at all times.
REQ-016 In ADDR, only the selected slave's arvalid SHALL be 1; on that slave's arready=1, the FSM SHALL go to DATA.
REQ-017 arvalid SHALL stay asserted with a stable address until the handshake completes; the first slave arvalid occurs in the cycle after master acceptance.
REQ-018 In DATA, rvalid, rdata and rresp SHALL be driven combinationally from the selected slave, and the selected slave's rready SHALL equal master rready.
REQ-019 In DATA, the R handshake (rvalid&rready) SHALL return the FSM to IDLE.
REQ-020 In ERR, the block SHALL drive rvalid=1, rdata=32'h0 and rresp=2'b11 (DECERR) until rready=1, then go to IDLE.
REQ-021 No slave arvalid SHALL be asserted for an unmapped access.
REQ-022 The unselected slave's arvalid and rready SHALL stay 0, and its rvalid/rdata SHALL be ignored.
REQ-023 When not in DATA or ERR: rvalid=0, rdata=0, rresp=0.
REQ-024 A master arvalid outside IDLE SHALL be ignored; the master holds its request until arready.
REQ-025 With rready held low, rvalid and payload SHALL stay stable and the FSM SHALL not advance.
REQ-026 After the R handshake in cycle M, arready SHALL be 1 in cycle M+1; there is no same-cycle turnaround.
REQ-027 SHALL implement no timeout; a non-responding slave stalls the block until reset.

Reset
REQ-028 Reset SHALL asynchronously force IDLE, the address register to 0 and the target register to SoC.
REQ-029 During reset, outputs SHALL be: arready=1, rvalid=0, rdata=0, rresp=0, clint_arvalid=0, soc_arvalid=0, clint_rready=0, soc_rready=0.
REQ-030 Reset asserted mid-transaction SHALL drop the transaction, deasserting slave arvalid/rready immediately without waiting for a clock edge.
REQ-031 The first transaction SHALL be accepted on the first rising clock edge after reset deasserts.

Verification
REQ-032 Read araddr=0x0200_0004 with clint_arready=1 and rready=1: clint_arvalid is high exactly one cycle, soc_arvalid stays 0, and the master receives clint_rdata with rresp=0.
REQ-033 Read araddr=0x8000_0000 with soc_arready low for 3 cycles: soc_arvalid is held 4 cycles with a stable address, then SoC data passes through unchanged.
REQ-034 Read araddr=0x0201_0000 (just past the CLINT window): no slave arvalid, and the master sees rvalid=1, rdata=0, rresp=2'b11.
REQ-035 CLINT read with rready low for 5 cycles: rvalid and rdata stay stable, clint_rready=0 throughout, and the handshake completes in cycle 6.
REQ-036 Back-to-back reads with arvalid held continuously: the second request is accepted exactly one cycle after the first R handshake.
REQ-037 Assert reset while in DATA: all slave strobes drop asynchronously, and after release arready=1 with no stale rvalid.
